// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the fetch requester (i_*), the load/store requester (d_*) and the
//   single-ported memory (mem_*) signals seen by the arbiter.
//
//   master : arbiter view. Accepts requests, drives the memory bus and
//            returns done/err/rdata to the requesters.
//   slave  : environment view. Requesters plus the memory.
//
//   Fetch     : i_req, i_addr -> i_ready, i_done, i_err, i_rdata
//   Load/store: d_req, d_we, d_addr, d_wdata, d_wstrb
//               -> d_ready, d_done, d_err, d_rdata
//   Memory    : mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
//               <- mem_ack, mem_rdata
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        i_done;
    logic        i_err;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ready;
    logic        d_done;
    logic        d_err;
    logic [31:0] d_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        input  i_req, i_addr,
        output i_ready, i_done, i_err, i_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_ready, d_done, d_err, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport slave (
        output i_req, i_addr,
        input  i_ready, i_done, i_err, i_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_ready, d_done, d_err, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported memory between the fetch requester (read-only)
//   and the load/store requester. Only one memory access is outstanding at a
//   time. Loads/stores normally win; a streak counter guarantees that a
//   waiting fetch gets through after MAX_D_STREAK contended data grants, and a
//   timeout aborts accesses the memory never acknowledges.
//
//   Parameters
//     MAX_D_STREAK : contended D grants allowed in a row before I is forced (>=1)
//     TIMEOUT      : mem_req cycles without mem_ack before abort (0 = never)
//
//   Ports
//     clk   : rising-edge clock
//     reset : asynchronous, active-low reset
//     bus   : requester and memory signals (mem_port_arbiter_if.master)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.master   bus
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    // The counter holds (mem_req cycles so far - 1), so it only needs to
    // reach TIMEOUT-1.
    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;

    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;

    logic        i_done_q, i_done_d;
    logic        i_err_q, i_err_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        d_done_q, d_done_d;
    logic        d_err_q, d_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic force_i;
    logic d_ready;
    logic i_ready;
    logic timeout_hit;

    // Grant decision. The readies are also gated by reset so that every
    // output reads 0 while reset is held, even with requests pending.
    always_comb begin
        force_i = bus.i_req && (streak_q == STREAK_MAX);
        d_ready = reset && (state_q == IDLE) && bus.d_req && !force_i;
        i_ready = reset && (state_q == IDLE) && bus.i_req && !d_ready;
        timeout_hit = (TIMEOUT != 0) && (tcnt_q == TCNT_LAST);
    end

    // Next-state logic. An ack in the last allowed cycle is checked before the
    // timeout, so it completes normally.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        tcnt_d      = tcnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        i_done_d    = 1'b0;
        i_err_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_done_d    = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (d_ready) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_wstrb_d = bus.d_wstrb;
                    if (bus.i_req && (streak_q != STREAK_MAX)) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (i_ready) begin
                    state_d     = BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.i_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    streak_d    = '0;
                end
            end

            BUSY_I, BUSY_D: begin
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    tcnt_d    = '0;
                    if (state_q == BUSY_I) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = bus.mem_rdata;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = mem_we_q ? 32'h0 : bus.mem_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    tcnt_d    = '0;
                    if (state_q == BUSY_I) begin
                        i_done_d  = 1'b1;
                        i_err_d   = 1'b1;
                        i_rdata_d = '0;
                    end else begin
                        d_done_d  = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end
                end else if (TIMEOUT != 0) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset abandons any access in flight
    // without reporting it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            tcnt_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            i_done_q    <= 1'b0;
            i_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_done_q    <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            tcnt_q      <= tcnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            i_done_q    <= i_done_d;
            i_err_q     <= i_err_d;
            i_rdata_q   <= i_rdata_d;
            d_done_q    <= d_done_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.i_ready   = i_ready;
    assign bus.i_done    = i_done_q;
    assign bus.i_err     = i_err_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ready   = d_ready;
    assign bus.d_done    = d_done_q;
    assign bus.d_err     = d_err_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;

endmodule
